// File: rtl/colorred_pkg.sv
// Shared types and defaults for the colour-reduction centroid update stage.
package colorred_pkg;

  localparam int K_DEFAULT     = 4;
  localparam int CH_W_DEFAULT  = 8;
  localparam int DIV_W_DEFAULT = 32;
  localparam int CLUSTER_W     = $clog2(K_DEFAULT);
  localparam int NUM_CH        = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_e;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_e;

endpackage

// File: rtl/cluster_accum.sv
// Per-cluster saturating R/G/B sum and pixel-count bank with a cluster/channel read mux.
module cluster_accum
  import colorred_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int CH_W  = CH_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_en,
  input  logic [$clog2(K)-1:0]   acc_cluster,
  input  logic [NUM_CH*CH_W-1:0] acc_pix,
  input  logic                   zero,
  input  logic [$clog2(K)-1:0]   rd_cluster,
  input  ch_e                    rd_ch,
  output logic [DIV_W-1:0]       rd_sum,
  output logic [DIV_W-1:0]       rd_cnt
);

  localparam int IDX_W = $clog2(K);

  logic [DIV_W-1:0] sum_all [K][NUM_CH];
  logic [DIV_W-1:0] cnt_all [K];

  for (genvar gi = 0; gi < K; gi++) begin : g_cluster
    logic             hit;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W:0]   cnt_ext;

    assign hit     = acc_en && (acc_cluster == IDX_W'(gi));
    assign cnt_ext = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};
    assign cnt_d   = cnt_ext[DIV_W] ? {DIV_W{1'b1}} : cnt_ext[DIV_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (zero) begin
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;

    for (genvar gj = 0; gj < NUM_CH; gj++) begin : g_ch
      logic [DIV_W-1:0] sum_q;
      logic [DIV_W-1:0] sum_d;
      logic [DIV_W:0]   sum_ext;

      // Carry out of the widened add means the sum would wrap: pin it at all-ones.
      assign sum_ext = {1'b0, sum_q} + {{(DIV_W + 1 - CH_W){1'b0}}, acc_pix[gj*CH_W +: CH_W]};
      assign sum_d   = sum_ext[DIV_W] ? {DIV_W{1'b1}} : sum_ext[DIV_W-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= '0;
        end else if (zero) begin
          sum_q <= '0;
        end else if (hit) begin
          sum_q <= sum_d;
        end
      end

      assign sum_all[gi][gj] = sum_q;
    end
  end

  always_comb begin
    rd_cnt = cnt_all[rd_cluster];
    rd_sum = sum_all[rd_cluster][0];
    case (rd_ch)
      CH_G:    rd_sum = sum_all[rd_cluster][1];
      CH_B:    rd_sum = sum_all[rd_cluster][2];
      default: rd_sum = sum_all[rd_cluster][0];
    endcase
  end

endmodule

// File: rtl/centroid_mean_seq.sv
// k-means centroid update: accumulate per-cluster sums over a frame, then divide each
// channel sum by its count through an external divider and emit one centroid beat per cluster.
module centroid_mean_seq
  import colorred_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int CH_W  = CH_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 pix_valid,
  input  logic [$clog2(K)-1:0] pix_cluster,
  input  logic [CH_W-1:0]      pix_r,
  input  logic [CH_W-1:0]      pix_g,
  input  logic [CH_W-1:0]      pix_b,
  input  logic                 frame_done,
  output logic                 div_start,
  output logic                 div_sign,
  output logic [DIV_W-1:0]     div_dividend,
  output logic [DIV_W-1:0]     div_divisor,
  input  logic [DIV_W-1:0]     div_quotient,
  input  logic                 div_ready,
  output logic                 cent_valid,
  output logic [$clog2(K)-1:0] cent_idx,
  output logic [CH_W-1:0]      cent_r,
  output logic [CH_W-1:0]      cent_g,
  output logic [CH_W-1:0]      cent_b,
  output logic                 cent_empty,
  output logic                 busy,
  output logic                 pix_dropped
);

  localparam int IDX_W = $clog2(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         clus_q;
  ch_e                      ch_q;
  logic                     guard_q;
  logic                     drop_q;
  logic [NUM_CH*CH_W-1:0]   res_q;
  logic [NUM_CH*CH_W-1:0]   held_all [K];
  logic [NUM_CH*CH_W-1:0]   held_rd;

  logic                     acc_en;
  logic                     acc_zero;
  logic [DIV_W-1:0]         rd_sum;
  logic [DIV_W-1:0]         rd_cnt;
  logic                     cnt_zero;
  logic                     quot_take;
  logic [DIV_W-CH_W-1:0]    unused_quot_hi;

  assign unused_quot_hi = div_quotient[DIV_W-1:CH_W];

  // Clear wins over a same-cycle pixel so a cleared frame starts truly empty.
  assign acc_en    = (state_q == IDLE) && pix_valid && !clear;
  assign acc_zero  = ((state_q == IDLE) && clear) || ((state_q == EMIT) && (clus_q == LAST_IDX));
  assign cnt_zero  = (rd_cnt == '0);
  // guard_q masks a late ready from a previous (possibly aborted) divide.
  assign quot_take = (state_q == WAIT) && div_ready && !guard_q;
  assign held_rd   = held_all[clus_q];

  cluster_accum #(
    .K     (K),
    .CH_W  (CH_W),
    .DIV_W (DIV_W)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_en      (acc_en),
    .acc_cluster (pix_cluster),
    .acc_pix     ({pix_b, pix_g, pix_r}),
    .zero        (acc_zero),
    .rd_cluster  (clus_q),
    .rd_ch       (ch_q),
    .rd_sum      (rd_sum),
    .rd_cnt      (rd_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_done && !clear) state_d = ISSUE;
      ISSUE:   state_d = cnt_zero ? EMIT : WAIT;
      WAIT:    if (quot_take) state_d = (ch_q == CH_B) ? EMIT : ISSUE;
      EMIT:    state_d = (clus_q == LAST_IDX) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    div_sign     = 1'b0;
    div_start    = (state_q == ISSUE) && !cnt_zero;
    div_dividend = '0;
    div_divisor  = '0;
    if (((state_q == ISSUE) && !cnt_zero) || (state_q == WAIT)) begin
      div_dividend = rd_sum;
      div_divisor  = rd_cnt;
    end
    cent_valid = (state_q == EMIT);
    cent_idx   = cent_valid ? clus_q : '0;
    cent_empty = cent_valid && cnt_zero;
    cent_r     = cent_valid ? res_q[0*CH_W +: CH_W] : '0;
    cent_g     = cent_valid ? res_q[1*CH_W +: CH_W] : '0;
    cent_b     = cent_valid ? res_q[2*CH_W +: CH_W] : '0;
    pix_dropped = drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clus_q  <= '0;
      ch_q    <= CH_R;
      guard_q <= 1'b0;
      res_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clus_q <= '0;
          ch_q   <= CH_R;
          if (clear) drop_q <= 1'b0;
        end
        ISSUE: begin
          guard_q <= 1'b1;
          if (cnt_zero) res_q <= held_rd;
        end
        WAIT: begin
          guard_q <= 1'b0;
          if (quot_take) begin
            res_q[int'(ch_q)*CH_W +: CH_W] <= div_quotient[CH_W-1:0];
            if (ch_q != CH_B) ch_q <= ch_e'(ch_q + 2'd1);
          end
        end
        EMIT: begin
          ch_q   <= CH_R;
          clus_q <= clus_q + 1'b1;
        end
        default: ;
      endcase
      if ((state_q != IDLE) && pix_valid) drop_q <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_held
    logic [NUM_CH*CH_W-1:0] held_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held_q <= '0;
      end else if ((state_q == EMIT) && (clus_q == IDX_W'(gi))) begin
        held_q <= res_q;
      end
    end

    assign held_all[gi] = held_q;
  end

endmodule

// File: tb/tb_centroid_mean_seq.sv
// Directed bench for centroid_mean_seq with a behavioural divider and a beat scoreboard.
module tb_centroid_mean_seq;

  localparam int K     = 4;
  localparam int CH_W  = 8;
  localparam int DIV_W = 32;
  localparam int LAT   = 3 * K * (DIV_W + 3) + K;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              pix_valid = 1'b0;
  logic [1:0]        pix_cluster = '0;
  logic [CH_W-1:0]   pix_r = '0, pix_g = '0, pix_b = '0;
  logic              frame_done = 1'b0;
  logic              div_start, div_sign;
  logic [DIV_W-1:0]  div_dividend, div_divisor;
  logic [DIV_W-1:0]  div_quotient = '0;
  logic              div_ready = 1'b0;
  logic              cent_valid;
  logic [1:0]        cent_idx;
  logic [CH_W-1:0]   cent_r, cent_g, cent_b;
  logic              cent_empty, busy, pix_dropped;

  always #5 clk = ~clk;

  centroid_mean_seq #(.K(K), .CH_W(CH_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pix_valid(pix_valid),
    .pix_cluster(pix_cluster), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_done(frame_done), .div_start(div_start), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_ready(div_ready),
    .cent_valid(cent_valid), .cent_idx(cent_idx), .cent_r(cent_r),
    .cent_g(cent_g), .cent_b(cent_b), .cent_empty(cent_empty),
    .busy(busy), .pix_dropped(pix_dropped)
  );

  typedef struct {
    logic [1:0]      idx;
    logic [CH_W-1:0] r, g, b;
    logic            empty;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int beats = 0;
  int last_beat_cyc = 0;
  int fd_cyc = 0;

  int              m_sum [K][3];
  int              m_cnt [K];
  logic [CH_W-1:0] m_held [K][3];

  bit               dv_pending = 0;
  int               dv_ready_cyc = 0;
  logic [DIV_W-1:0] dv_a = '0, dv_b = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: ready pulses DIV_W+2 cycles after the start cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n && dv_pending && cyc == dv_ready_cyc) begin
      div_ready    = 1'b1;
      div_quotient = (dv_b == 0) ? '1 : dv_a / dv_b;
    end else begin
      div_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      dv_pending = 0;
    end else begin
      if (div_start) begin
        starts++;
        dv_pending   = 1;
        dv_a         = div_dividend;
        dv_b         = div_divisor;
        dv_ready_cyc = cyc + DIV_W + 2;
      end else if (dv_pending && cyc == dv_ready_cyc) begin
        check("div_dividend_stable", div_dividend, dv_a);
        check("div_divisor_stable", div_divisor, dv_b);
        dv_pending = 0;
      end
      if (cent_valid) begin
        beats++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("beat idx=%0d rgb=%0d,%0d,%0d empty=%0d (exp idx=%0d rgb=%0d,%0d,%0d empty=%0d)",
                   cent_idx, cent_r, cent_g, cent_b, cent_empty,
                   mon_e.idx, mon_e.r, mon_e.g, mon_e.b, mon_e.empty);
          check("cent_idx", cent_idx, mon_e.idx);
          check("cent_r", cent_r, mon_e.r);
          check("cent_g", cent_g, mon_e.g);
          check("cent_b", cent_b, mon_e.b);
          check("cent_empty", cent_empty, mon_e.empty);
        end
      end
    end
  end

  task automatic model_clear_sums();
    for (int c = 0; c < K; c++) begin
      m_cnt[c] = 0;
      for (int ch = 0; ch < 3; ch++) m_sum[c][ch] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear_sums();
    for (int c = 0; c < K; c++)
      for (int ch = 0; ch < 3; ch++) m_held[c][ch] = '0;
  endtask

  task automatic push_expect();
    beat_t e;
    for (int c = 0; c < K; c++) begin
      e.idx = 2'(c);
      e.empty = (m_cnt[c] == 0);
      if (m_cnt[c] != 0)
        for (int ch = 0; ch < 3; ch++) m_held[c][ch] = CH_W'(m_sum[c][ch] / m_cnt[c]);
      e.r = m_held[c][0];
      e.g = m_held[c][1];
      e.b = m_held[c][2];
      exp_q.push_back(e);
    end
    model_clear_sums();
  endtask

  // Drive one pixel; optionally raise frame_done in the same cycle.
  task automatic send_pix(input int c, input int r, input int g, input int b, input bit fd = 1'b0);
    pix_valid = 1'b1; pix_cluster = 2'(c);
    pix_r = CH_W'(r); pix_g = CH_W'(g); pix_b = CH_W'(b);
    frame_done = fd;
    m_sum[c][0] += r; m_sum[c][1] += g; m_sum[c][2] += b; m_cnt[c]++;
    if (fd) fd_cyc = cyc;
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_done = 1'b0;
    if (fd) push_expect();
  endtask

  task automatic drop_pix(input int c, input int r, input int g, input int b);
    pix_valid = 1'b1; pix_cluster = 2'(c);
    pix_r = CH_W'(r); pix_g = CH_W'(g); pix_b = CH_W'(b);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic do_frame();
    fd_cyc = cyc;
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    push_expect();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_beats_pending"}, exp_q.size(), 0);
    @(posedge clk); #1;
    check({tag, "_busy_cleared"}, busy, 0);
  endtask

  initial begin
    int s0, b0, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_cent_valid", cent_valid, 0);
    check("reset_div_start", div_start, 0);
    check("reset_pix_dropped", pix_dropped, 0);
    check("reset_div_dividend", div_dividend, 0);
    check("reset_div_sign", div_sign, 0);

    // Four pixels to c0; c1..c3 empty with held zeros.
    s0 = starts;
    send_pix(0, 10, 5, 100);
    send_pix(0, 20, 6, 101);
    send_pix(0, 30, 7, 102);
    send_pix(0, 40, 8, 103);
    do_frame();
    check("t1_busy_after_frame_done", busy, 1);
    wait_done("t1");
    check("t1_div_starts", starts - s0, 3);

    // Pixel coincident with frame_done must be counted; c0 reuses held centroid.
    s0 = starts;
    send_pix(1, 100, 0, 9);
    send_pix(2, 7, 7, 7);
    send_pix(1, 200, 255, 0, 1'b1);
    wait_done("t2");
    check("t2_div_starts", starts - s0, 6);

    // Pixel during busy is dropped; clear during busy is ignored.
    send_pix(3, 90, 80, 70);
    send_pix(3, 10, 20, 30);
    do_frame();
    repeat (5) @(posedge clk);
    #1;
    drop_pix(3, 255, 255, 255);
    check("t3_pix_dropped_set", pix_dropped, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t3_busy_after_clear_in_busy", busy, 1);
    wait_done("t3");
    check("t3_pix_dropped_sticky", pix_dropped, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t3_pix_dropped_cleared", pix_dropped, 0);

    // clear + frame_done together: clear wins, no sequence starts.
    send_pix(2, 200, 200, 200);
    clear = 1'b1; frame_done = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; frame_done = 1'b0;
    model_clear_sums();
    check("t4_busy_after_clear_fd", busy, 0);
    send_pix(2, 4, 8, 12);
    do_frame();
    wait_done("t4");

    // Reset asserted during the WAIT of cluster 2.
    for (int c = 0; c < K; c++) send_pix(c, 11 * (c + 1), 22 + c, 33 + c);
    do_frame();
    b0 = beats; n = 0;
    while (beats - b0 < 2 && n < 2000) begin @(posedge clk); #1; n++; end
    s0 = starts;
    while (starts == s0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("t5_reached_c2_divide", (starts > s0), 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cent_valid", cent_valid, 0);
    check("t5_rst_div_start", div_start, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_div_dividend", div_dividend, 0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    s0 = starts;
    for (int c = 0; c < K; c++) send_pix(c, 50 + c, 60 + c, 70 + c);
    for (int c = 0; c < K; c++) send_pix(c, 51 + c, 63 + c, 75 + c);
    do_frame();
    wait_done("t5_rerun");
    check("t5_rerun_div_starts", starts - s0, 12);
    check("t5_rerun_latency", last_beat_cyc - fd_cyc, LAT);

    // Random 1000-pixel frame, every cluster populated.
    for (int i = 0; i < 1000; i++)
      send_pix((i < K) ? i : int'($urandom_range(0, K - 1)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
    s0 = starts;
    do_frame();
    wait_done("t6");
    check("t6_div_starts", starts - s0, 12);
    check("t6_latency", last_beat_cyc - fd_cyc, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
